// File: rtl/serial_tx_sched_pkg.sv
// serial_tx_sched_pkg
//   Shared definitions for the serial link scheduler and its round-robin
//   arbiter: flit geometry, grant index width and transmit state encoding.
package serial_tx_sched_pkg;

    localparam int PAYLOAD_SIZE = 4;
    localparam int ADDR_SZ      = 4;
    localparam int FLIT_W       = PAYLOAD_SIZE + ADDR_SZ;

    // Wide enough for up to 8 requesters.
    localparam int GRANT_IDX_W  = 3;

    typedef enum logic [1:0] {
        TXS_IDLE = 2'd0,
        TXS_SEND = 2'd1,
        TXS_WAIT = 2'd2
    } txs_state_t;

endpackage

// File: rtl/serial_tx_sched_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a registered priority pointer. The search starts
//   at the pointer and wraps upward. When 'advance' is high and a grant exists,
//   the pointer moves to the index just past the winner.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset (pointer -> 0)
//   req       in   N_REQ request vector
//   advance   in   the current grant was taken; move the pointer
//   grant     out  one-hot grant (all zero when no request)
//   grant_idx out  binary index of the granted requester
module rr_arbiter
    import serial_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic                   advance,
    output logic [N_REQ-1:0]       grant,
    output logic [GRANT_IDX_W-1:0] grant_idx
);

    logic [GRANT_IDX_W-1:0] ptr;
    logic                   found;
    logic [2*N_REQ-1:0]     req_dbl;

    // Rotate the requests so that bit 0 is the pointer position. The
    // duplicated vector makes the wrap-around free.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        req_dbl   = {req, req} >> ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_dbl[k]) begin
                found     = 1'b1;
                grant_idx = GRANT_IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = found && (grant_idx == GRANT_IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == GRANT_IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_sched.sv
// serial_tx_sched
//   Shares one serial link toward a dclk-style serial receiver among N_REQ
//   flit sources. It picks a winner round-robin, captures its flit and sends
//   the frame: a start bit (1), W data bits LSB first, then a guard bit (0).
//   After each frame it waits until the receiver drops channel_busy.
// Ports:
//   clk          in   link clock (the receiver's wclk)
//   reset        in   synchronous active-high reset; aborts a frame at once
//   req          in   N_REQ per-requester flit valid
//   flit_in      in   N_REQ*W flits, requester i at [i*W +: W]
//   ack          out  one-hot one-cycle capture pulse
//   grant_id     out  index of the requester being served
//   channel_busy in   receiver busy; no new frame may start while high
//   serial_out   out  registered serial line
//   tx_busy      out  high whenever not IDLE
module serial_tx_sched
    import serial_tx_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int W        = FLIT_W,
    parameter int routerid = -1,
    parameter     port     = "unknown"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*W-1:0]     flit_in,
    output logic [N_REQ-1:0]       ack,
    output logic [GRANT_IDX_W-1:0] grant_id,
    input  logic                   channel_busy,
    output logic                   serial_out,
    output logic                   tx_busy
);

    localparam int                CNT_W    = $clog2(W + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W + 1);

    // routerid and port only identify the instance during debug; reject
    // impossible configurations at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || W < 1 || routerid < -1 || $bits(port) == 0) begin : g_param_check
        $error("serial_tx_sched: unsupported parameter set");
    end

    txs_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [W-1:0]           shift, shift_nxt;
    logic                   serial_nxt;
    logic [GRANT_IDX_W-1:0] grant_id_nxt;

    logic [N_REQ-1:0]       arb_grant;
    logic [GRANT_IDX_W-1:0] arb_idx;
    logic                   start;
    logic [W-1:0]           sel_flit;

    // A frame may only begin from IDLE with a free channel.
    assign start   = (state == TXS_IDLE) && (|req) && !channel_busy;
    assign tx_busy = (state != TXS_IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (start),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) sel_flit = flit_in[i*W +: W];
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shift_nxt    = shift;
        serial_nxt   = serial_out;
        grant_id_nxt = grant_id;
        ack          = '0;
        case (state)
            TXS_IDLE: begin
                serial_nxt = 1'b0;
                if (start) begin
                    ack          = arb_grant;
                    shift_nxt    = sel_flit;
                    grant_id_nxt = arb_idx;
                    serial_nxt   = 1'b1;
                    cnt_nxt      = CNT_W'(1);
                    state_nxt    = TXS_SEND;
                end
            end
            TXS_SEND: begin
                // channel_busy is deliberately not looked at while sending.
                if (cnt == CNT_LAST) begin
                    serial_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = TXS_WAIT;
                end else begin
                    serial_nxt = shift[0];
                    shift_nxt  = shift >> 1;
                    cnt_nxt    = cnt + 1'b1;
                end
            end
            TXS_WAIT: begin
                serial_nxt = 1'b0;
                if (!channel_busy) state_nxt = TXS_IDLE;
            end
            default: begin
                serial_nxt = 1'b0;
                cnt_nxt    = '0;
                state_nxt  = TXS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= TXS_IDLE;
            cnt        <= '0;
            shift      <= '0;
            serial_out <= 1'b0;
            grant_id   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shift      <= shift_nxt;
            serial_out <= serial_nxt;
            grant_id   <= grant_id_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx_sched.sv
module tb_serial_tx_sched;
    import serial_tx_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] flit_in;
    logic [N-1:0]   ack;
    logic [2:0]     grant_id;
    logic           channel_busy;
    logic           serial_out;
    logic           tx_busy;

    logic rx_busy;
    logic ext_busy;
    logic item_read;

    assign channel_busy = rx_busy | ext_busy;

    always #5 clk = ~clk;

    serial_tx_sched #(
        .N_REQ (N),
        .W     (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .flit_in      (flit_in),
        .ack          (ack),
        .grant_id     (grant_id),
        .channel_busy (channel_busy),
        .serial_out   (serial_out),
        .tx_busy      (tx_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the link is occupied for the W+2 frame bits, then
    // until the first cycle the receiver reports free.
    int           m_ptr;
    logic [2:0]   m_gid;
    bit           m_wire[$];
    bit           m_wait;
    logic [W-1:0] m_exp[$];
    logic [N-1:0] last_ack;

    // Receiver model: 0 idle, 1 receiving, 2 holding an item.
    int           rx_state;
    int           rx_n;
    logic [W-1:0] rx_data;
    logic [W-1:0] rx_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] rnd_flit();
        if ($urandom_range(0, 7) == 0) return '0;
        return W'($urandom);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_gid = '0;
        m_wire.delete();
        m_exp.delete();
        m_wait = 0;
        last_ack = '0;
    endtask

    // Evaluated mid-cycle while every signal is stable.
    task automatic monitor();
        logic [N-1:0] exp_ack;
        bit           exp_busy;
        bit           exp_ser;
        int           g;
        if (reset) begin
            model_reset();
            return;
        end
        exp_busy = (m_wire.size() != 0) || m_wait;
        chk("tx_busy", tx_busy, exp_busy);
        chk("grant_id", grant_id, m_gid);
        if (m_wire.size() != 0) begin
            exp_ser = m_wire.pop_front();
            if (m_wire.size() == 0) m_wait = channel_busy;
        end else begin
            exp_ser = 0;
            if (m_wait && !channel_busy) m_wait = 0;
        end
        chk("serial_out", serial_out, exp_ser);
        exp_ack = '0;
        if (!exp_busy && (|req) && !channel_busy) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            exp_ack[g] = 1'b1;
            m_ptr = (g + 1) % N;
            m_gid = 3'(g);
            m_wire.push_back(1'b1);
            for (int b = 0; b < W; b++) m_wire.push_back(flit_in[g*W + b]);
            m_wire.push_back(1'b0);
            m_exp.push_back(flit_in[g*W +: W]);
        end
        chk("ack", ack, exp_ack);
        last_ack = ack;
    endtask

    task automatic rx_update();
        if (reset) begin
            rx_state = 0;
            rx_busy  = 1'b0;
            return;
        end
        case (rx_state)
            0: if (serial_out) begin
                rx_state = 1;
                rx_n     = 0;
                rx_busy  = 1'b1;
            end
            1: if (rx_n < W) begin
                rx_data[rx_n] = serial_out;
                rx_n++;
            end else begin
                chk("guard_bit", serial_out, 1'b0);
                rx_last = rx_data;
                chk("rx_frame_expected", m_exp.size() != 0, 1'b1);
                if (m_exp.size() != 0) chk("rx_flit", rx_data, m_exp.pop_front());
                rx_state = 2;
            end
            default: ;
        endcase
        if (rx_state == 2 && item_read) begin
            rx_state = 0;
            rx_busy  = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        rx_update();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 300 && (tx_busy || rx_state != 0 || m_wire.size() != 0)) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 300, 1'b1);
    endtask

    function automatic int ack_index(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return i;
        return -1;
    endfunction

    initial begin
        bit           t1_wire[10] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0};
        int           exp_order[5] = '{0, 1, 2, 3, 0};
        int           got[$];
        int           n;
        logic [N-1:0] acc;

        reset     = 1'b1;
        req       = '0;
        flit_in   = '0;
        ext_busy  = 1'b0;
        item_read = 1'b1;
        rx_busy   = 1'b0;
        rx_state  = 0;
        rx_n      = 0;
        rx_data   = '0;
        rx_last   = '0;
        model_reset();

        // Reset values
        tick(); tick(); tick();
        chk("rst_serial_out", serial_out, 1'b0);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_grant_id", grant_id, 3'd0);
        chk("rst_ack", ack, '0);
        reset = 1'b0;
        tick();

        // Single requester, 0xA5
        flit_in[0 +: W] = 8'hA5;
        req = 4'b0001;
        #1;
        chk("t1_ack_same_cycle", ack, 4'b0001);
        tick();
        req = '0;
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("t1_wire%0d", j), serial_out, t1_wire[j]);
            tick();
        end
        chk("t1_rx_item", rx_last, 8'hA5);
        wait_idle();

        // All requesters active: strict rotation from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) flit_in[i*W +: W] = rnd_flit();
        req = '1;
        n = 0;
        while (n < 300 && got.size() < 5) begin
            tick();
            n++;
            if (last_ack != '0) begin
                got.push_back(ack_index(last_ack));
                flit_in[ack_index(last_ack)*W +: W] = rnd_flit();
            end
        end
        chk("t2_timeout", got.size(), 5);
        for (int j = 0; j < 5 && j < got.size(); j++) chk($sformatf("t2_order%0d", j), got[j], exp_order[j]);
        req = '0;
        wait_idle();

        // Receiver stalls with the item unread
        item_read = 1'b0;
        flit_in[0 +: W] = rnd_flit();
        req = 4'b0001;
        n = 0;
        do begin tick(); n++; end while (n < 20 && last_ack == '0);
        chk("t3_first_ack", last_ack, 4'b0001);
        req = '0;
        for (int j = 0; j < W + 2; j++) tick();
        for (int i = 0; i < N; i++) flit_in[i*W +: W] = rnd_flit();
        req = '1;
        for (int j = 0; j < 50; j++) begin
            tick();
            chk("t3_no_ack", last_ack, '0);
            chk("t3_line_low", serial_out, 1'b0);
            chk("t3_tx_busy", tx_busy, 1'b1);
        end
        item_read = 1'b1;
        n = 0;
        do begin tick(); n++; end while (n < 10 && !serial_out);
        chk("t3_restart_latency_ok", n <= 3, 1'b1);
        req = '0;
        wait_idle();

        // External busy rising together with req[2]
        flit_in[2*W +: W] = rnd_flit();
        req = 4'b0100;
        ext_busy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("t4_held_off", last_ack, '0);
        end
        ext_busy = 1'b0;
        tick();
        chk("t4_ack2", last_ack, 4'b0100);
        req = '0;
        wait_idle();

        // Reset in the middle of a frame (SEND count 4)
        flit_in[3*W +: W] = 8'hFF;
        req = 4'b1000;
        tick();
        chk("t5_ack3", last_ack, 4'b1000);
        req = '0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_serial_out", serial_out, 1'b0);
        chk("t5_tx_busy", tx_busy, 1'b0);
        chk("t5_grant_id", grant_id, 3'd0);
        for (int i = 0; i < N; i++) flit_in[i*W +: W] = rnd_flit();
        req = '1;
        tick();
        chk("t5_first_after_reset", last_ack, 4'b0001);
        req = '0;
        wait_idle();

        // Withdrawn request while busy never gets acked; pointer stays
        req = 4'b0001;
        tick();
        chk("t6_ack0", last_ack, 4'b0001);
        req = '0;
        acc = '0;
        tick(); acc |= last_ack;
        tick(); acc |= last_ack;
        req = 4'b0010;
        tick(); acc |= last_ack;
        tick(); acc |= last_ack;
        req = '0;
        tick(); acc |= last_ack;
        chk("t6_pulse_not_acked", acc, '0);
        wait_idle();
        for (int i = 0; i < N; i++) flit_in[i*W +: W] = rnd_flit();
        req = '1;
        tick();
        chk("t6_pointer_kept", last_ack, 4'b0010);
        req = '0;
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            item_read = ($urandom_range(0, 9) < 7);
            if (ext_busy) ext_busy = ($urandom_range(0, 3) != 0);
            else          ext_busy = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                if (last_ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    flit_in[i*W +: W] = rnd_flit();
                end else if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    flit_in[i*W +: W] = rnd_flit();
                    req[i] = 1'b1;
                end
            end
            tick();
        end
        req = '0;
        ext_busy = 1'b0;
        item_read = 1'b1;
        wait_idle();
        chk("end_all_frames_received", m_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
